// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - command sequencer driving the 8x4 register file write/read port
`timescale 1ns/1ps

module regfile_ctrl #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [WIDTH-1:0]  rf_q,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [WIDTH-1:0]  rf_din,
    output logic              rf_load,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_FILL,
        S_CP_RD,
        S_CP_WR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic [WIDTH-1:0]  w_q;
    logic [WIDTH-1:0]  tmp;
    logic [WIDTH-1:0]  rd_q;
    logic [ADDR_W-1:0] fill_cnt;
    logic              fill_last;

    assign fill_last = (fill_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            w_q      <= '0;
            tmp      <= '0;
            rd_q     <= '0;
            fill_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Command fields are captured once so host inputs may change while busy.
            if (state == S_IDLE && start) begin
                a_q      <= a_addr;
                b_q      <= b_addr;
                w_q      <= wdata;
                fill_cnt <= '0;
            end
            if (state == S_FILL && !fill_last) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (state == S_RD) begin
                rd_q <= rf_q;
            end
            if (state == S_CP_RD) begin
                tmp <= rf_q;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_WRITE: state_nxt = S_WR;
                        OP_READ:  state_nxt = S_RD;
                        OP_FILL:  state_nxt = S_FILL;
                        OP_COPY:  state_nxt = S_CP_RD;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WR:    state_nxt = S_DONE;
            S_RD:    state_nxt = S_DONE;
            S_FILL:  state_nxt = fill_last ? S_DONE : S_FILL;
            S_CP_RD: state_nxt = S_CP_WR;
            S_CP_WR: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Port outputs depend only on registered state, never on host inputs.
    always_comb begin
        rf_addr = '0;
        rf_din  = '0;
        rf_load = 1'b0;
        case (state)
            S_WR: begin
                rf_addr = a_q;
                rf_din  = w_q;
                rf_load = 1'b1;
            end
            S_RD: begin
                rf_addr = a_q;
            end
            S_FILL: begin
                rf_addr = fill_cnt;
                rf_din  = w_q;
                rf_load = 1'b1;
            end
            S_CP_RD: begin
                rf_addr = b_q;
            end
            S_CP_WR: begin
                rf_addr = a_q;
                rf_din  = tmp;
                rf_load = 1'b1;
            end
            default: begin
                rf_addr = '0;
            end
        endcase
    end

    assign rd_data = rd_q;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - directed table-driven bench for regfile_ctrl
`timescale 1ns/1ps

module tb_regfile_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [2:0] a_addr;
    logic [2:0] b_addr;
    logic [3:0] wdata;
    logic [3:0] rf_q;
    logic [2:0] rf_addr;
    logic [3:0] rf_din;
    logic       rf_load;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;

    logic [3:0] mem [8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] w;
        logic [3:0] ld_din;
        logic [3:0] rd;
    } cmd_t;

    cmd_t vec[$];

    regfile_ctrl #(.WIDTH(4), .ADDR_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .wdata   (wdata),
        .rf_q    (rf_q),
        .rf_addr (rf_addr),
        .rf_din  (rf_din),
        .rf_load (rf_load),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_load) mem[rf_addr] <= rf_din;
    end
    assign rf_q = mem[rf_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                                input logic [3:0] w, input logic [3:0] ld_din, input logic [3:0] rd);
        cmd_t c;
        c.op = o; c.a = a; c.b = b; c.w = w; c.ld_din = ld_din; c.rd = rd;
        return c;
    endfunction

    task automatic run_cmd(input cmd_t c);
        int cyc, loads, exp_lat, exp_loads;
        logic got, seq_ok, busy1;
        logic [2:0] c1_addr, ld_addr, exp_c1;
        logic [3:0] ld_din;
        exp_lat   = (c.op == 2'b10) ? 9 : (c.op == 2'b11) ? 3 : 2;
        exp_loads = (c.op == 2'b10) ? 8 : (c.op == 2'b01) ? 0 : 1;
        exp_c1    = (c.op == 2'b10) ? 3'd0 : (c.op == 2'b11) ? c.b : c.a;
        @(negedge clk);
        start = 1'b1; op = c.op; a_addr = c.a; b_addr = c.b; wdata = c.w;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); a_addr = 3'($urandom);
        b_addr = 3'($urandom); wdata = 4'($urandom);
        cyc = 0; loads = 0; got = 1'b0; seq_ok = 1'b1; busy1 = 1'b0;
        c1_addr = '0; ld_addr = '0; ld_din = '0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                c1_addr = rf_addr;
                busy1   = busy;
            end
            if (rf_load) begin
                if (loads == 0) begin
                    ld_addr = rf_addr;
                    ld_din  = rf_din;
                end
                if (c.op == 2'b10 && (rf_addr != 3'(loads) || rf_din != c.w)) seq_ok = 1'b0;
                loads++;
            end
            if (done) got = 1'b1;
        end
        chk("done_seen", int'(got), 1);
        chk("done_latency", cyc, exp_lat);
        chk("busy_cycle1", int'(busy1), 1);
        chk("addr_cycle1", int'(c1_addr), int'(exp_c1));
        chk("load_count", loads, exp_loads);
        if (exp_loads > 0) begin
            chk("load_addr", int'(ld_addr), (c.op == 2'b10) ? 0 : int'(c.a));
            chk("load_din", int'(ld_din), int'(c.ld_din));
        end
        if (c.op == 2'b10) chk("fill_sequence", int'(seq_ok), 1);
        chk("rd_data", int'(rd_data), int'(c.rd));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, int'({rf_addr, rf_din, rf_load, rd_data, busy, done}), 0);
    endtask

    initial begin
        int loads, dn, dn_cyc;
        reset = 1'b1; start = 1'b0; op = '0; a_addr = '0; b_addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_outputs");
        reset = 1'b0;

        vec.push_back(mk(2'b00, 3'd5, 3'd0, 4'hA, 4'hA, 4'h0));
        vec.push_back(mk(2'b01, 3'd5, 3'd0, 4'h0, 4'h0, 4'hA));
        vec.push_back(mk(2'b10, 3'd0, 3'd0, 4'h3, 4'h3, 4'hA));
        for (int i = 0; i < 8; i++) vec.push_back(mk(2'b01, 3'(i), 3'd0, 4'h0, 4'h0, 4'h3));
        vec.push_back(mk(2'b00, 3'd2, 3'd0, 4'h7, 4'h7, 4'h3));
        vec.push_back(mk(2'b00, 3'd6, 3'd0, 4'h1, 4'h1, 4'h3));
        vec.push_back(mk(2'b01, 3'd6, 3'd0, 4'h0, 4'h0, 4'h1));
        vec.push_back(mk(2'b11, 3'd6, 3'd2, 4'h0, 4'h7, 4'h1));
        vec.push_back(mk(2'b01, 3'd6, 3'd0, 4'h0, 4'h0, 4'h7));
        vec.push_back(mk(2'b01, 3'd2, 3'd0, 4'h0, 4'h0, 4'h7));
        vec.push_back(mk(2'b11, 3'd5, 3'd5, 4'h0, 4'h3, 4'h7));
        vec.push_back(mk(2'b01, 3'd5, 3'd0, 4'h0, 4'h0, 4'h3));
        foreach (vec[i]) run_cmd(vec[i]);

        // Busy rejection: start pulses during FILL and during DONE are dropped.
        @(negedge clk);
        start = 1'b1; op = 2'b10; wdata = 4'h5;
        @(posedge clk);
        #1;
        start = 1'b0;
        loads = 0; dn = 0; dn_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rf_load) loads++;
            if (done) begin
                dn++;
                dn_cyc = c;
            end
            start = (c == 3 || c == 9); op = 2'b00; a_addr = 3'd0; wdata = 4'hF;
        end
        start = 1'b0;
        chk("busy_reject_loads", loads, 8);
        chk("busy_reject_dones", dn, 1);
        chk("busy_reject_done_cycle", dn_cyc, 9);
        run_cmd(mk(2'b01, 3'd0, 3'd0, 4'h0, 4'h0, 4'h5));

        // Reset in the 4th FILL load cycle.
        run_cmd(mk(2'b00, 3'd4, 3'd0, 4'h9, 4'h9, 4'h5));
        run_cmd(mk(2'b00, 3'd5, 3'd0, 4'hA, 4'hA, 4'h5));
        run_cmd(mk(2'b00, 3'd6, 3'd0, 4'hB, 4'hB, 4'h5));
        run_cmd(mk(2'b00, 3'd7, 3'd0, 4'hC, 4'hC, 4'h5));
        run_cmd(mk(2'b01, 3'd7, 3'd0, 4'h0, 4'h0, 4'hC));
        @(negedge clk);
        start = 1'b1; op = 2'b10; wdata = 4'h6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("fill_4th_load_addr", int'({rf_load, rf_addr}), int'({1'b1, 3'd3}));
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset_mid_fill_outputs");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) run_cmd(mk(2'b01, 3'(i), 3'd0, 4'h0, 4'h0, 4'h6));
        run_cmd(mk(2'b01, 3'd4, 3'd0, 4'h0, 4'h0, 4'h9));
        run_cmd(mk(2'b01, 3'd5, 3'd0, 4'h0, 4'h0, 4'hA));
        run_cmd(mk(2'b01, 3'd6, 3'd0, 4'h0, 4'h0, 4'hB));
        run_cmd(mk(2'b01, 3'd7, 3'd0, 4'h0, 4'h0, 4'hC));
        run_cmd(mk(2'b00, 3'd3, 3'd0, 4'hD, 4'hD, 4'hC));
        run_cmd(mk(2'b01, 3'd3, 3'd0, 4'h0, 4'h0, 4'hD));

        // Reset and start together: the command is dropped.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 2'b00; a_addr = 3'd1; wdata = 4'hF;
        @(negedge clk);
        chk("reset_start_busy", int'({busy, rf_load}), 0);
        reset = 1'b0; start = 1'b0;
        loads = 0; dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (rf_load || busy) loads++;
            if (done) dn++;
        end
        chk("reset_start_idle", loads, 0);
        chk("reset_start_no_done", dn, 0);
        run_cmd(mk(2'b01, 3'd1, 3'd0, 4'h0, 4'h0, 4'h6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
